// File: rtl/sum_tree_seq_if.sv
// Handshake bundle for sum_tree_seq: operand vector in, reduced sum out.
// The slave side is the summation engine; the master side is producer plus consumer.
interface sum_tree_seq_if #(
    parameter int N  = 45,
    parameter int W  = 5,
    parameter int OW = W + $clog2(N)
);
    logic            in_valid;
    logic            in_ready;
    logic [N*W-1:0]  in_data;
    logic            out_valid;
    logic            out_ready;
    logic [OW-1:0]   out_sum;
    logic            busy;

    modport master (
        output in_valid, in_data, out_ready,
        input  in_ready, out_valid, out_sum, busy
    );

    modport slave (
        input  in_valid, in_data, out_ready,
        output in_ready, out_valid, out_sum, busy
    );
endinterface

// File: rtl/sum_tree_seq.sv
// Multi-cycle reduction of N W-bit operands to one OW-bit sum using P shared
// two-input adders; each RUN cycle pairs the low live entries and compacts the rest.
module sum_tree_seq #(
    parameter int N      = 45,
    parameter int W      = 5,
    parameter int P      = 10,
    parameter bit SIGNED = 1'b0
) (
    input logic           clk,
    input logic           rst,
    sum_tree_seq_if.slave bus
);
    localparam int OW = W + $clog2(N);
    localparam int CW = $clog2(N + 1);
    // PA is the most adds any cycle can use; PN bounds the physical adder bank.
    localparam int PA = (P < N / 2) ? P : N / 2;
    localparam int PN = (P < N) ? P : N;

    typedef enum logic [1:0] {
        S_IDLE,
        S_RUN,
        S_DONE
    } state_t;

    state_t          state_q, state_d;
    logic [CW-1:0]   c_q, c_d;
    logic [OW-1:0]   e_q [N];
    logic [OW-1:0]   e_d [N];
    logic [OW-1:0]   pair_sum [PN];
    int              c_n;
    int              a_n;

    // Adder k always reduces the fixed pair (2k, 2k+1).
    for (genvar k = 0; k < PN; k++) begin : g_adder
        if (2 * k + 1 < N) begin : g_used
            assign pair_sum[k] = e_q[2*k] + e_q[2*k+1];
        end else begin : g_tied
            assign pair_sum[k] = '0;
        end
    end

    always_comb begin
        // NOTE: every variable gets a default before the case so no path can infer a latch.
        state_d = state_q;
        c_d     = c_q;
        e_d     = e_q;
        c_n     = int'(c_q);
        a_n     = (c_n / 2 < PA) ? c_n / 2 : PA;

        unique case (state_q)
            S_IDLE: begin
                if (bus.in_valid) begin
                    for (int i = 0; i < N; i++) begin
                        if (SIGNED) begin
                            e_d[i] = OW'(signed'(bus.in_data[i*W +: W]));
                        end else begin
                            e_d[i] = OW'(bus.in_data[i*W +: W]);
                        end
                    end
                    c_d     = CW'(N);
                    state_d = (N > 1) ? S_RUN : S_DONE;
                end
            end
            S_RUN: begin
                // Survivors slide down by a; the low a slots are then overwritten by pair sums.
                for (int m = 0; m <= PA; m++) begin
                    if (a_n == m) begin
                        for (int i = 0; i < N - m; i++) begin
                            e_d[i] = e_q[i + m];
                        end
                    end
                end
                for (int i = 0; i < PN; i++) begin
                    if (i < a_n) begin
                        e_d[i] = pair_sum[i];
                    end
                end
                c_d = CW'(c_n - a_n);
                if (c_n - a_n == 1) begin
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            c_q     <= '0;
            // NOTE: the entry array is cleared on reset because out_sum reads e[0] and must show 0.
            for (int i = 0; i < N; i++) begin
                e_q[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q <= state_d;
            c_q     <= c_d;
            e_q     <= e_d;
        end
    end

    assign bus.in_ready  = (state_q == S_IDLE);
    assign bus.out_valid = (state_q == S_DONE);
    assign bus.busy      = (state_q == S_RUN);
    assign bus.out_sum   = e_q[0];
endmodule

// File: doc/sum_tree_seq.md
# sum_tree_seq

Parametrised multi-cycle summation engine: accepts N operands of W bits in one handshake and reduces them to a single sum using a bank of P shared two-input adders over K cycles. K is fixed by N and P. It is the generic successor of the fixed N/K summation blocks. It supports unsigned or signed operands and provides valid/ready handshakes on both sides, so it can sit between a producer stage and a result consumer in the datapath.

## Interface
- N, default 45: operand count, N ≥ 1.
- W, default 5: operand width in bits, W ≥ 2.
- P, default 10: number of physical adders, P ≥ 1.
- SIGNED, default 0: 0 treats operands as unsigned (zero-extend); 1 treats them as two's complement (sign-extend).
- Derived: OW = W + $clog2(N) (OW = W when N = 1).
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  reset rst, synchronous, active-high.
- in_valid  in  1  operand vector valid.
- in_ready  out  1  block can accept an operand vector.
- in_data  in  N*W  packed operands; operand i occupies bits [i*W +: W].
- out_valid  out  1  out_sum holds a completed result.
- out_ready  in  1  consumer accepts the result.
- out_sum  out  OW  sum of all N operands, extended to OW per SIGNED.
- busy  out  1  high in RUN state.

## Operation
- **State machine:** three states, IDLE, RUN and DONE. Reset enters IDLE.
- **Internal state:** an entry array e[0..N-1] of OW bits each, plus a live-count register c of width $clog2(N+1).
- **IDLE:**
  - in_ready = 1.
  - On in_valid && in_ready, e[i] is loaded with extend(in_data operand i) and c is set to N.
  - Next state is RUN if N > 1, otherwise DONE.
- **RUN, per cycle with live count c:**
  - Adds performed: a = min(P, floor(c/2)).
  - Pair sums: next e[i] = e[2i] + e[2i+1] for i < a.
  - Compaction: next e[a+j] = e[2a+j] for j < c−2a.
  - Next live count: c = c − a.
  - When the next c equals 1, next state is DONE.
  - Entries at index ≥ c are don't-care.
- **DONE:**
  - out_valid = 1 and out_sum = e[0].
  - On out_ready, next state is IDLE.
  - out_sum holds stable while out_valid && !out_ready.
- **Arithmetic:** all additions are OW bits wide and cannot overflow, for both unsigned and signed operands. The operand order of each pairwise add is fixed as above, so the result is bit-exact against a reference sum.
- **Input handshake:** in_ready = 1 only in IDLE. in_valid outside IDLE is ignored, with no buffering. in_data is sampled only on the accept edge.
- **Output handshake:** out_valid = 1 only in DONE. out_ready outside DONE is ignored.
- **Adder use:** exactly P adders exist. Cycles with a < P leave the remaining adders idle.

## Timing
- **Reset:** rst high at an edge forces state IDLE, c = 0, e[] = 0, from any state including mid-RUN and DONE. An in-flight operation is discarded and never produces out_valid.
- **Output values after reset:**
  - in_ready = 1
  - out_valid = 0
  - out_sum = 0
  - busy = 0
- **Cycle count:** K is the number of RUN iterations for N, P. K = 0 when N = 1.
  - N=45, P=10: 45→35→25→15→8→4→2→1, K = 7.
  - N=8, P=4: 8→4→2→1, K = 3.
  - N=8, P=1: K = 7.
- **Latency:**
  - Accept edge at cycle t; out_valid asserts after edge t+K, i.e. it is visible in cycle t+K+1.
  - For N = 1, out_valid is visible in cycle t+1.
- **Turnaround:**
  - DONE exits on the out_ready edge; in_ready is visible the following cycle.
  - Minimum spacing between accepts is K+2 cycles.
- **Output timing:** all outputs are registered-state decodes, with no combinational path from in_valid or out_ready to any output.

## Test plan
- **Unsigned, full range:** N=45, W=5, P=10, SIGNED=0, all operands 31 → out_sum = 1395; out_valid first high exactly 8 cycles after the accept cycle; busy high for 7 cycles.
- **Ordered operands, two configurations:** N=8, W=4, P=4, operands 0..7 → out_sum = 28 after K = 3. Same with P=1 → out_sum = 28 after K = 7.
- **Signed:** SIGNED=1, N=4, W=4, operands −8, −8, 7, 1 → out_sum = −8 (6-bit 0x38). Unsigned build with the same bits (8, 8, 7, 1) → 24.
- **Backpressure:**
  - Hold out_ready = 0 for 5 cycles in DONE → out_sum and out_valid stable, in_ready = 0.
  - in_valid pulses during RUN/DONE are ignored.
  - After out_ready, a new vector is accepted one cycle later.
- **Reset mid-operation:** assert rst at RUN cycle 3 of the N=45 case → next cycle IDLE, out_valid = 0, out_sum = 0, in_ready = 1. A following vector of all 1s → 45.
- **Degenerate count:** N=1, W=5, operand 17 → out_valid the cycle after accept, out_sum = 17, busy never asserts.
